regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the pipelined datapath. Provides NUM_RD

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_rd_port.sv | 47 ++++
 rtl/regfile_mp.sv | 89 ++++++++
 tb/tb_regfile_mp.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 4;
  localparam int RF_PC_IDX = 15;

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;
  typedef logic [RF_DATA_W-1:0] reg_data_t;

  typedef struct packed {
    logic      we;
    reg_addr_t wa;
    reg_data_t wd;
  } wr_port_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: PC alias, write bypass and busy qualification.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int BYPASS = 1,
  parameter int PC_IDX = RF_PC_IDX,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       ra,
  input  logic [DATA_W-1:0]       r15,
  input  logic                    we0,
  input  logic [ADDR_W-1:0]       wa0,
  input  logic [DATA_W-1:0]       wd0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       wa1,
  input  logic [DATA_W-1:0]       wd1,
  input  logic [DEPTH*DATA_W-1:0] mem,
  input  logic [DEPTH-1:0]        lock,
  output logic [DATA_W-1:0]       rd,
  output logic                    busy
);

  logic is_pc;
  logic hit0;
  logic hit1;

  assign is_pc = (ra == ADDR_W'(PC_IDX));
  // Bypass is suppressed during reset so held reset reads stay at zero.
  assign hit1 = (BYPASS != 0) && !rst && we1 && (wa1 == ra);
  assign hit0 = (BYPASS != 0) && !rst && we0 && (wa0 == ra);

  always_comb begin
    rd = mem[int'(ra)*DATA_W +: DATA_W];
    if (is_pc)
      rd = r15;
    else if (hit1)
      rd = wd1;
    else if (hit0)
      rd = wd0;
  end

  assign busy = !is_pc && lock[ra] && !(hit0 || hit1);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD read ports, two write ports,
// and a pending-load lock scoreboard exposed through busy[].
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 3,
  parameter int BYPASS = 1,
  parameter int PC_IDX = RF_PC_IDX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     lock_en,
  input  logic [ADDR_W-1:0]        lock_addr,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0]        r15,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH*DATA_W-1:0] mem;
  logic [DEPTH-1:0]        lock;

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    if (g == PC_IDX) begin : g_pc
      // The PC lives in fetch; this slot is never stored or locked.
      assign mem[g*DATA_W +: DATA_W] = '0;
      assign lock[g] = 1'b0;
    end else begin : g_st
      logic hit0;
      logic hit1;
      assign hit0 = we0 && (wa0 == ADDR_W'(g));
      assign hit1 = we1 && (wa1 == ADDR_W'(g));

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          mem[g*DATA_W +: DATA_W] <= '0;
        else if (hit1)
          mem[g*DATA_W +: DATA_W] <= wd1;
        else if (hit0)
          mem[g*DATA_W +: DATA_W] <= wd0;
      end

      // A new load issue outranks a completing writeback.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          lock[g] <= 1'b0;
        else if (lock_en && (lock_addr == ADDR_W'(g)))
          lock[g] <= 1'b1;
        else if (hit0 || hit1)
          lock[g] <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS),
      .PC_IDX (PC_IDX),
      .DEPTH  (DEPTH)
    ) u_rd (
      .rst  (rst),
      .ra   (ra[i*ADDR_W +: ADDR_W]),
      .r15  (r15),
      .we0  (we0),
      .wa0  (wa0),
      .wd0  (wd0),
      .we1  (we1),
      .wa1  (wa1),
      .wd1  (wd1),
      .mem  (mem),
      .lock (lock),
      .rd   (rd[i*DATA_W +: DATA_W]),
      .busy (busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp with directed vectors.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic        clk;
  logic        rst;
  logic        we0;
  logic [3:0]  wa0;
  logic [31:0] wd0;
  logic        we1;
  logic [3:0]  wa1;
  logic [31:0] wd1;
  logic        lock_en;
  logic [3:0]  lock_addr;
  logic [11:0] ra;
  logic [31:0] r15;
  logic [95:0] rd;
  logic [2:0]  busy;

  typedef struct {
    int          port;
    logic [31:0] rd;
    logic        busy;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp;
  int   n_bad;
  event smp;

  regfile_mp dut (
    .clk       (clk),
    .rst       (rst),
    .we0       (we0),
    .wa0       (wa0),
    .wd0       (wd0),
    .we1       (we1),
    .wa1       (wa1),
    .wd1       (wd1),
    .lock_en   (lock_en),
    .lock_addr (lock_addr),
    .ra        (ra),
    .r15       (r15),
    .rd        (rd),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(smp);
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] a_rd;
        logic        a_b;
        e = q.pop_front();
        a_rd = rd[e.port*32 +: 32];
        a_b = busy[e.port];
        n_cmp++;
        if (a_rd !== e.rd || a_b !== e.busy) begin
          n_bad++;
          $display("FAIL %s port%0d: got rd=%h busy=%b, want rd=%h busy=%b",
                   e.name, e.port, a_rd, a_b, e.rd, e.busy);
        end
      end
    end
  end

  task automatic expect_rd(input int p, input logic [31:0] v,
                           input logic b, input string n);
    exp_t e;
    e.port = p;
    e.rd = v;
    e.busy = b;
    e.name = n;
    q.push_back(e);
  endtask

  task automatic sample();
    #1;
    ->smp;
    #1;
  endtask

  task automatic setra(input logic [3:0] a0, input logic [3:0] a1,
                       input logic [3:0] a2);
    ra = {a2, a1, a0};
  endtask

  task automatic idle();
    we0 = 0;
    we1 = 0;
    lock_en = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1;
    idle();
    wa0 = 0; wd0 = 0; wa1 = 0; wd1 = 0;
    lock_addr = 0; r15 = 4;
    setra(3, 4, 15);

    // 1 reset held, then released
    @(negedge clk);
    expect_rd(0, 32'h0, 1'b0, "rst_held_r3");
    expect_rd(2, 32'h4, 1'b0, "rst_held_pc");
    sample();
    @(negedge clk);
    rst = 0;
    expect_rd(0, 32'h0, 1'b0, "rst_r3");
    expect_rd(1, 32'h0, 1'b0, "rst_r4");
    expect_rd(2, 32'h4, 1'b0, "rst_pc");
    sample();

    // 2 write then read, with bypass
    @(negedge clk);
    we0 = 1; wa0 = 1; wd0 = 7;
    setra(1, 4, 15);
    expect_rd(0, 32'h7, 1'b0, "wr_bypass");
    sample();
    @(negedge clk);
    idle();
    expect_rd(0, 32'h7, 1'b0, "wr_stored");
    sample();

    // 3 collision, W1 wins
    @(negedge clk);
    we0 = 1; wa0 = 5; wd0 = 32'hAA;
    we1 = 1; wa1 = 5; wd1 = 32'h55;
    setra(5, 1, 15);
    expect_rd(0, 32'h55, 1'b0, "coll_bypass");
    expect_rd(1, 32'h7, 1'b0, "coll_other");
    sample();
    @(negedge clk);
    idle();
    expect_rd(0, 32'h55, 1'b0, "coll_stored");
    sample();

    // 4 PC alias ignores writes
    @(negedge clk);
    we0 = 1; wa0 = 15; wd0 = 32'hDEAD; r15 = 32'h108;
    setra(15, 5, 1);
    expect_rd(0, 32'h108, 1'b0, "pc_wcycle");
    sample();
    @(negedge clk);
    idle();
    expect_rd(0, 32'h108, 1'b0, "pc_after");
    sample();

    // 5 lock scoreboard
    @(negedge clk);
    lock_en = 1; lock_addr = 2;
    setra(15, 2, 15);
    expect_rd(1, 32'h0, 1'b0, "lock_not_yet");
    sample();
    @(negedge clk);
    idle();
    expect_rd(1, 32'h0, 1'b1, "lock_busy");
    sample();
    @(negedge clk);
    we1 = 1; wa1 = 2; wd1 = 9;
    expect_rd(1, 32'h9, 1'b0, "lock_wb_bypass");
    sample();
    @(negedge clk);
    idle();
    expect_rd(1, 32'h9, 1'b0, "lock_cleared");
    sample();
    @(negedge clk);
    lock_en = 1; lock_addr = 3;
    we0 = 1; wa0 = 3; wd0 = 32'h33;
    setra(15, 2, 3);
    expect_rd(2, 32'h33, 1'b0, "setclr_cycle");
    sample();
    @(negedge clk);
    idle();
    expect_rd(2, 32'h33, 1'b1, "set_wins");
    sample();
    @(negedge clk);
    lock_en = 1; lock_addr = 15;
    setra(15, 2, 3);
    expect_rd(0, 32'h108, 1'b0, "lock_pc_ign");
    sample();

    // 6 fill 1..14, lock 14, then async reset mid-cycle
    for (int i = 1; i < 15; i++) begin
      @(negedge clk);
      idle();
      we0 = 1; wa0 = 4'(i); wd0 = 32'(i * 32'h11);
    end
    @(negedge clk);
    idle();
    lock_en = 1; lock_addr = 14;
    @(negedge clk);
    idle();
    setra(7, 14, 3);
    expect_rd(0, 32'h77, 1'b0, "fill_r7");
    expect_rd(1, 32'hEE, 1'b1, "fill_r14_busy");
    expect_rd(2, 32'h33, 1'b0, "fill_r3_unlock");
    sample();
    rst = 1;
    expect_rd(0, 32'h0, 1'b0, "arst_r7");
    expect_rd(1, 32'h0, 1'b0, "arst_r14");
    expect_rd(2, 32'h0, 1'b0, "arst_r3");
    sample();
    rst = 0;
    @(negedge clk);
    expect_rd(1, 32'h0, 1'b0, "arst_after");
    sample();

    #2;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
